// File: rtl/fdiv_iter.sv
// ---------------------------------------------------------------------------
// fdiv_iter -- multi-cycle IEEE-754 binary32 divider, res = x / y
//
// Exact-result divider for the FPU execute stage. The mantissa quotient is
// produced by restoring long division, one bit per clock, with no lookup
// tables. Only one operation is in flight at a time. Subnormal inputs are
// treated as zero and subnormal results are flushed to zero.
//
// Configuration macro:
//   FDIV_ROUND_EN  defined   -> round-to-nearest-even
//                  undefined -> truncation (round toward zero), no incrementer
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   in_valid   in   operands x/y valid
//   in_ready   out  divider idle, can accept
//   x          in   dividend, binary32
//   y          in   divisor, binary32
//   out_valid  out  res valid
//   out_ready  in   consumer accepts res
//   res        out  quotient, binary32
//
// Timing: normal operands give out_valid 27 edges after the accept edge;
// special operands (zero/inf/NaN) give out_valid 1 edge after accept.
// ---------------------------------------------------------------------------
module fdiv_iter #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  state_t       state, next_state;
  logic [4:0]   cnt;
  logic         sign;
  logic [7:0]   ex, ey;
  logic [23:0]  my;
  logic [24:0]  rem;
  logic [25:0]  q;
  logic [31:0]  spec_res;

  // Operand classification at the input port (used only on accept)
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic        in_sign;
  logic        is_special;
  logic [31:0] spec_val;

  assign in_sign = x[31] ^ y[31];
  assign x_zero  = (x[30:23] == 8'h00);
  assign y_zero  = (y[30:23] == 8'h00);
  assign x_inf   = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  assign y_inf   = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
  assign x_nan   = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  assign y_nan   = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);

  // Special-case decode. Exponent 0 counts as zero whatever the mantissa,
  // which is how subnormal inputs get flushed. Priority order matters:
  // the invalid cases must win over the divide-by-zero and inf cases.
  always_comb begin
    is_special = 1'b1;
    spec_val   = 32'h0000_0000;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
      spec_val = 32'h7FC0_0000;
    else if (y_zero)
      spec_val = {in_sign, 31'h7F80_0000};
    else if (x_inf)
      spec_val = {in_sign, 31'h7F80_0000};
    else if (x_zero || y_inf)
      spec_val = {in_sign, 31'h0000_0000};
    else
      is_special = 1'b0;
  end

  // One restoring division step: subtract the divisor when it fits, then
  // shift. The remainder always stays below 2*my, so 25 bits suffice.
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;

  assign rem_ge   = (rem >= {1'b0, my});
  assign rem_sub  = rem - {1'b0, my};
  assign rem_next = rem_ge ? {rem_sub[23:0], 1'b0} : {rem[23:0], 1'b0};

  // Normalisation: the quotient lies in [0.5, 2), so the leading one is
  // either q[25] or q[24]. The exponent is kept in signed 10-bit form so
  // that both overflow and underflow are visible before packing.
  logic               q_hi;
  logic [22:0]        mant;
  logic signed [9:0]  e_base;
  logic signed [9:0]  e_pre;
  logic signed [9:0]  e_fin;
  logic [22:0]        mant_fin;
  logic [31:0]        norm_res;

  assign q_hi   = q[25];
  assign e_base = $signed({2'b00, ex}) - $signed({2'b00, ey});
  assign mant   = q_hi ? q[24:2] : q[23:1];
  assign e_pre  = q_hi ? (e_base + 10'sd127) : (e_base + 10'sd126);

`ifdef FDIV_ROUND_EN
  logic        guard, sticky, round_inc;
  logic [23:0] mant_sum;

  assign guard     = q_hi ? q[1] : q[0];
  assign sticky    = (q_hi & q[0]) | (rem != 25'd0);
  assign round_inc = guard & (sticky | mant[0]);
  assign mant_sum  = {1'b0, mant} + {23'd0, round_inc};
  // A carry out of the mantissa means the value rounded up to the next
  // power of two: the fraction becomes zero and the exponent bumps by one.
  assign mant_fin  = mant_sum[22:0];
  assign e_fin     = mant_sum[23] ? (e_pre + 10'sd1) : e_pre;
`else
  logic unused_trunc;

  // Guard and sticky bits only matter when rounding is enabled.
  assign unused_trunc = q[0];
  assign mant_fin     = mant;
  assign e_fin        = e_pre;
`endif

  always_comb begin
    if (e_fin >= 10'sd255)
      norm_res = {sign, 8'hFF, 23'd0};
    else if (e_fin <= 10'sd0)
      norm_res = {sign, 31'd0};
    else
      norm_res = {sign, e_fin[7:0], mant_fin};
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic. DONE is only left once a result has actually been
  // presented and taken, which also covers the special-case path where
  // DONE is entered one edge before out_valid rises.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = is_special ? DONE : DIV;
      DIV:  if (cnt == LAST_STEP) next_state = NORM;
      NORM: next_state = DONE;
      DONE: if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Datapath and output registers. Reset wipes everything so an aborted
  // operation can never leak out as a result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= 5'd0;
      sign      <= 1'b0;
      ex        <= 8'd0;
      ey        <= 8'd0;
      my        <= 24'd0;
      rem       <= 25'd0;
      q         <= 26'd0;
      spec_res  <= 32'd0;
      res       <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= in_sign;
            ex       <= x[30:23];
            ey       <= y[30:23];
            my       <= {1'b1, y[22:0]};
            rem      <= {2'b01, x[22:0]};
            q        <= 26'd0;
            cnt      <= 5'd0;
            spec_res <= spec_val;
          end
        end
        DIV: begin
          q   <= {q[24:0], rem_ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          res       <= norm_res;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            res       <= spec_res;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fdiv_iter.md
Name: fdiv_iter

Overview:
- Multi-cycle IEEE-754 single-precision divider, res = x / y, for the FPU execute stage.
- The exact-result counterpart to the table-driven reciprocal-approximation path: a restoring long division of the mantissas, with no ROMs.
- Valid/ready handshake on both sides. One operation in flight at a time.
- Shares the FPU subnormal policy: subnormal inputs are flushed to zero and subnormal results are flushed to zero.

Parameters:
- ITER, 26, number of quotient bits generated: 24 mantissa + 1 guard + 1 normalisation bit. Fixed for binary32; any other value is unsupported.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operands x/y valid
- in_ready  out  1  divider idle, can accept
- x  in  32  dividend, binary32
- y  in  32  divisor, binary32
- out_valid  out  1  res valid
- out_ready  in  1  consumer accepts res
- res  out  32  quotient, binary32

Behaviour:
- Reset: one clock; reset asynchronous, active-low (rstn).
  - rstn low forces state IDLE, out_valid=0, res=0, and clears all internal registers, regardless of operation in progress.
  - A partially computed result is discarded and never emitted.
- States: IDLE, DIV, NORM, DONE.
- in_ready = (state==IDLE), combinational.
- Accept at edge t0 when in_valid & in_ready. Latch sign = x[31]^y[31], the exponents, and mantissas mx={1,x[22:0]}, my={1,y[22:0]}.
- Special-case decode at accept (exp 0 = zero, exp 255 = inf/NaN). If a case applies, go directly to DONE; out_valid=1 after edge t1.
  - Any NaN input, 0/0, or inf/inf -> 0x7FC00000.
  - y zero, x nonzero finite -> {sign,0x7F800000}.
  - x inf, y finite -> signed inf.
  - x zero, or y inf with x finite -> {sign,31'b0}.
- Otherwise go to DIV.
- DIV: one restoring step per edge, ITER edges (t1..t26).
  - If rem >= my: q bit 1, rem -= my; else q bit 0.
  - rem <<= 1 after each step.
  - Initial rem = mx. Counter counts 0..ITER-1, then go to NORM.
- NORM (edge t27): q in [0.5,2).
  - q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(rem!=0), e=ex-ey+127.
  - q[25]=0: mant=q[23:1], guard=q[0], sticky=(rem!=0), e=ex-ey+126.
  - e is computed in signed 10-bit arithmetic.
  - Rounding is applied (see Optional Feature). A mantissa carry-out increments e.
  - e>=255 -> signed inf. e<=0 -> signed zero.
  - Write res; out_valid=1; go to DONE.
- Latency (normal operands): out_valid high after edge 27 relative to the accept edge.
- DONE: res and out_valid held stable while out_ready=0.
  - On an edge with out_valid & out_ready: out_valid=0, go to IDLE.
  - No accept in that same cycle, since in_ready was 0.
- Throughput: 1 result per 29 cycles minimum with out_ready tied high.
- While not IDLE, in_valid, x and y are ignored. Operands need not be held stable after accept.

Optional Feature:
- Macro FDIV_ROUND_EN.
- Defined: round-to-nearest-even. Increment mant if guard & (sticky | mant[0]). The carry into bit 23 renormalises with e+1 and may overflow to inf.
- Undefined: truncation (round toward zero). guard/sticky are ignored and the rounding incrementer is not synthesised. Latency is identical either way.

Test Plan:
- x=0x40C00000 (6.0), y=0x40000000 (2.0), out_ready=1 -> res=0x40400000, out_valid exactly 27 cycles after the accept edge, in_ready back high 1 cycle after output handshake.
- x=0x3F800000, y=0x40400000 (1/3) -> res=0x3EAAAAAB with FDIV_ROUND_EN, 0x3EAAAAAA without.
- x=0xC0C00000, y=0x40000000 -> 0xC0400000; x=0x3F800000, y=0x00000000 -> 0x7F800000 one cycle after accept; x=0, y=0 -> 0x7FC00000.
- x=0x7F000000, y=0x3E800000 -> 0x7F800000 (overflow); x=0x00800000, y=0x4B000000 -> 0x00000000 (underflow flush).
- Hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with new operands -> res/out_valid unchanged, in_ready=0, new operands never accepted; release -> single transfer.
- Assert rstn=0 asynchronously mid-DIV (cycle 10) -> out_valid=0 and res=0 immediately, no stale output afterwards; next operation 6.0/2.0 completes correctly with normal latency.
